// File: rtl/branch_target_buffer_table.sv
// Direct-mapped branch target buffer: per-entry valid/tag/target/saturating counter,
// registered one-cycle lookup, execute-stage update port with allocate-on-taken, and flush.

module btb_entry #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 26,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             upd_sel,
    input  logic             upd_taken,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [XLEN-1:0]  upd_target,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [XLEN-1:0]  target,
    output logic             ctr_msb
);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] ctr;
    logic             tag_hit;

    assign tag_hit = valid && (tag == upd_tag);
    assign ctr_msb = ctr[CTR_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= CTR_WNT;
        end else if (flush) begin
            // flush wins over a same-cycle update; only valid bits are cleared
            valid <= 1'b0;
        end else if (upd_sel) begin
            if (tag_hit) begin
                if (upd_taken) begin
                    target <= upd_target;
                    if (ctr != CTR_MAX) ctr <= ctr + CTR_W'(1);
                end else if (ctr != '0) begin
                    ctr <= ctr - CTR_W'(1);
                end
            end else if (upd_taken) begin
                valid  <= 1'b1;
                tag    <= upd_tag;
                target <= upd_target;
                ctr    <= CTR_WT;
            end
        end
    end
endmodule

module branch_target_buffer_table #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic            btb_clk,
    input  logic            btb_rst_n,
    input  logic            btb_flush,
    input  logic            btb_lookup_valid,
    input  logic [XLEN-1:0] btb_lookup_pc,
    output logic            btb_pred_valid,
    output logic            btb_pred_hit,
    output logic            btb_pred_taken,
    output logic [XLEN-1:0] btb_pred_target,
    input  logic            btb_upd_valid,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic            btb_upd_taken,
    input  logic [XLEN-1:0] btb_upd_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0]             ent_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  ent_tag;
    logic [ENTRIES-1:0][XLEN-1:0]   ent_target;
    logic [ENTRIES-1:0]             ent_msb;

    logic [IDX_W-1:0] upd_idx, rd_idx;
    logic [TAG_W-1:0] upd_tag, rd_tag;
    logic             rd_hit;
    logic             unused_pc_lsbs;

    assign upd_idx = btb_upd_pc[IDX_W+1:2];
    assign upd_tag = btb_upd_pc[XLEN-1:IDX_W+2];
    assign rd_idx  = btb_lookup_pc[IDX_W+1:2];
    assign rd_tag  = btb_lookup_pc[XLEN-1:IDX_W+2];
    assign unused_pc_lsbs = ^{btb_lookup_pc[1:0], btb_upd_pc[1:0]};

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        btb_entry #(.XLEN(XLEN), .TAG_W(TAG_W), .CTR_W(CTR_W)) u_entry (
            .clk        (btb_clk),
            .rst_n      (btb_rst_n),
            .flush      (btb_flush),
            .upd_sel    (btb_upd_valid && (upd_idx == IDX_W'(g))),
            .upd_taken  (btb_upd_taken),
            .upd_tag    (upd_tag),
            .upd_target (btb_upd_target),
            .valid      (ent_valid[g]),
            .tag        (ent_tag[g]),
            .target     (ent_target[g]),
            .ctr_msb    (ent_msb[g])
        );
    end

    // Read sees pre-edge array contents, so same-cycle updates are not forwarded.
    assign rd_hit = btb_lookup_valid && ent_valid[rd_idx] && (ent_tag[rd_idx] == rd_tag);

    always_ff @(posedge btb_clk or negedge btb_rst_n) begin
        if (!btb_rst_n) begin
            btb_pred_valid  <= 1'b0;
            btb_pred_hit    <= 1'b0;
            btb_pred_taken  <= 1'b0;
            btb_pred_target <= '0;
        end else begin
            btb_pred_valid  <= btb_lookup_valid;
            btb_pred_hit    <= rd_hit;
            btb_pred_taken  <= rd_hit && ent_msb[rd_idx];
            btb_pred_target <= rd_hit ? ent_target[rd_idx] : '0;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer_table.sv
// Vector-table bench for the BTB: expected predictions are queued at lookup and checked on response.

module tb_branch_target_buffer_table;
    logic        btb_clk = 1'b0;
    logic        btb_rst_n = 1'b0;
    logic        btb_flush = 1'b0;
    logic        btb_lookup_valid = 1'b0;
    logic [31:0] btb_lookup_pc = '0;
    logic        btb_pred_valid, btb_pred_hit, btb_pred_taken;
    logic [31:0] btb_pred_target;
    logic        btb_upd_valid = 1'b0;
    logic [31:0] btb_upd_pc = '0;
    logic        btb_upd_taken = 1'b0;
    logic [31:0] btb_upd_target = '0;

    branch_target_buffer_table #(.XLEN(32), .ENTRIES(16), .CTR_W(2)) dut (
        .btb_clk          (btb_clk),
        .btb_rst_n        (btb_rst_n),
        .btb_flush        (btb_flush),
        .btb_lookup_valid (btb_lookup_valid),
        .btb_lookup_pc    (btb_lookup_pc),
        .btb_pred_valid   (btb_pred_valid),
        .btb_pred_hit     (btb_pred_hit),
        .btb_pred_taken   (btb_pred_taken),
        .btb_pred_target  (btb_pred_target),
        .btb_upd_valid    (btb_upd_valid),
        .btb_upd_pc       (btb_upd_pc),
        .btb_upd_taken    (btb_upd_taken),
        .btb_upd_target   (btb_upd_target)
    );

    always #5 btb_clk = ~btb_clk;

    typedef struct {
        logic        flush;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        lk_valid;
        logic [31:0] lk_pc;
        logic        exp_hit;
        logic        exp_taken;
        logic [31:0] exp_target;
        string       name;
    } vec_t;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic fl, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utg, input logic lv,
                                input logic [31:0] lpc, input logic eh, input logic et,
                                input logic [31:0] etg, input string nm);
        vec_t v;
        v.flush = fl; v.upd_valid = uv; v.upd_pc = upc; v.upd_taken = ut; v.upd_target = utg;
        v.lk_valid = lv; v.lk_pc = lpc; v.exp_hit = eh; v.exp_taken = et; v.exp_target = etg;
        v.name = nm;
        return v;
    endfunction

    task automatic check_pred(input string nm, input logic h, input logic t, input logic [31:0] tg);
        tests++;
        if (btb_pred_hit !== h || btb_pred_taken !== t || btb_pred_target !== tg) begin
            fails++;
            $display("FAIL %s: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     nm, btb_pred_hit, btb_pred_taken, btb_pred_target, h, t, tg);
        end
    endtask

    task automatic check_valid(input string nm, input logic want);
        tests++;
        if (btb_pred_valid !== want) begin
            fails++;
            $display("FAIL %s pred_valid: got %b want %b", nm, btb_pred_valid, want);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge btb_clk);
        btb_flush        = v.flush;
        btb_upd_valid    = v.upd_valid;
        btb_upd_pc       = v.upd_pc;
        btb_upd_taken    = v.upd_taken;
        btb_upd_target   = v.upd_target;
        btb_lookup_valid = v.lk_valid;
        btb_lookup_pc    = v.lk_pc;
        if (v.lk_valid) begin
            e.hit = v.exp_hit; e.taken = v.exp_taken; e.target = v.exp_target; e.name = v.name;
            sb.push_back(e);
        end
        @(posedge btb_clk);
        #1;
        check_valid(v.name, v.lk_valid);
        if (btb_pred_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s: pred_valid=1 with no lookup outstanding", v.name);
            end else begin
                e = sb.pop_front();
                check_pred(e.name, e.hit, e.taken, e.target);
            end
        end else begin
            check_pred({v.name, "_idle"}, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic idle_inputs();
        btb_flush = 1'b0; btb_upd_valid = 1'b0; btb_upd_taken = 1'b0;
        btb_lookup_valid = 1'b0;
    endtask

    initial begin
        // fl upd  upc  ut  utgt  lk  lpc  exp hit/taken/target
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h100,0,0,32'h0,  "cold_miss"));
        vecs.push_back(mk(0,1,32'h100,1,32'h200, 0,32'h0,  0,0,32'h0,  "alloc_100"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h100,1,1,32'h200,"hit_wt"));
        vecs.push_back(mk(0,1,32'h100,1,32'h200, 0,32'h0,  0,0,32'h0,  "inc_3"));
        vecs.push_back(mk(0,1,32'h100,1,32'h200, 0,32'h0,  0,0,32'h0,  "sat_hi"));
        vecs.push_back(mk(0,1,32'h100,0,32'h0,   0,32'h0,  0,0,32'h0,  "dec_2"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h100,1,1,32'h200,"after_sat_dec"));
        vecs.push_back(mk(0,1,32'h100,0,32'h0,   1,32'h100,1,1,32'h200,"rbw_dec"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h100,1,0,32'h200,"weak_nt"));
        vecs.push_back(mk(0,1,32'h100,0,32'h0,   0,32'h0,  0,0,32'h0,  "dec_0"));
        vecs.push_back(mk(0,1,32'h100,0,32'h0,   0,32'h0,  0,0,32'h0,  "sat_lo"));
        vecs.push_back(mk(0,1,32'h100,1,32'h204, 0,32'h0,  0,0,32'h0,  "inc_1_tgt"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h100,1,0,32'h204,"after_sat_lo"));
        vecs.push_back(mk(0,1,32'h100,1,32'h200, 1,32'h100,1,0,32'h204,"rbw_inc"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h100,1,1,32'h200,"back_taken"));
        vecs.push_back(mk(0,1,32'h100,0,32'hDEAD,0,32'h0,  0,0,32'h0,  "nt_keeps_tgt"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h102,1,0,32'h200,"pc_lsb_ignored"));
        vecs.push_back(mk(0,1,32'h104,0,32'h400, 0,32'h0,  0,0,32'h0,  "nt_miss_upd"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h104,0,0,32'h0,  "nt_no_alloc"));
        vecs.push_back(mk(0,1,32'h140,1,32'h300, 0,32'h0,  0,0,32'h0,  "alias_140"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h100,0,0,32'h0,  "alias_evict"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h140,1,1,32'h300,"alias_hit"));
        vecs.push_back(mk(0,1,32'h180,1,32'h380, 1,32'h180,0,0,32'h0,  "same_cyc_alloc"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h180,1,1,32'h380,"next_cyc_hit"));
        vecs.push_back(mk(0,1,32'h03C,1,32'h500, 0,32'h0,  0,0,32'h0,  "alloc_idx15"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h03C,1,1,32'h500,"idx15_hit"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h07C,0,0,32'h0,  "idx15_tag_miss"));
        vecs.push_back(mk(1,1,32'h1C0,1,32'h600, 1,32'h180,1,1,32'h380,"flush_rbw"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h1C0,0,0,32'h0,  "flush_drops_upd"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h180,0,0,32'h0,  "flush_idx0"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h03C,0,0,32'h0,  "flush_idx15"));
        vecs.push_back(mk(0,1,32'h1C0,1,32'h600, 0,32'h0,  0,0,32'h0,  "realloc"));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,   1,32'h1C0,1,1,32'h600,"realloc_hit"));

        // reset state
        repeat (3) @(posedge btb_clk);
        #1;
        check_valid("reset", 1'b0);
        check_pred("reset", 1'b0, 1'b0, 32'h0);
        @(negedge btb_clk);
        btb_rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);
        @(negedge btb_clk);
        idle_inputs();

        // async reset between lookup response and next edge clears outputs at once
        @(negedge btb_clk);
        btb_lookup_valid = 1'b1;
        btb_lookup_pc    = 32'h1C0;
        @(posedge btb_clk);
        #1;
        check_valid("pre_reset_resp", 1'b1);
        check_pred("pre_reset_resp", 1'b1, 1'b1, 32'h600);
        btb_rst_n = 1'b0;
        #1;
        check_valid("async_reset", 1'b0);
        check_pred("async_reset", 1'b0, 1'b0, 32'h0);
        @(negedge btb_clk);
        btb_lookup_valid = 1'b0;
        @(negedge btb_clk);
        btb_rst_n = 1'b1;
        @(posedge btb_clk);
        #1;
        check_valid("post_reset_idle", 1'b0);
        apply(mk(0,0,32'h0,0,32'h0,1,32'h1C0,0,0,32'h0,"post_reset_miss"));
        @(negedge btb_clk);
        idle_inputs();

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
